// File: rtl/csr_access_arbiter.sv
// Single owner of the comparator CSR register-file port: arbitrates CPU Avalon-MM transfers against comparator status bit-sets.
// Optional round-robin tie-break under CSR_ARB_ROUND_ROBIN_EN; default build gives the comparator fixed priority.
module csr_access_arbiter #(
  parameter int                    ADDR_WIDTH   = 10,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    KEY_WIDTH    = 4,
  parameter logic [ADDR_WIDTH-1:0] SUCCESS_ADDR = 10'h010,
  parameter logic [ADDR_WIDTH-1:0] FAIL_ADDR    = 10'h011,
  parameter logic [ADDR_WIDTH-1:0] EXC_ADDR     = 10'h012
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] csr_address,
  input  logic                  csr_read,
  input  logic                  csr_write,
  input  logic [DATA_WIDTH-1:0] csr_writedata,
  output logic [DATA_WIDTH-1:0] csr_readdata,
  output logic                  csr_waitrequest,
  input  logic                  comp_status_write,
  input  logic [KEY_WIDTH-1:0]  comp_current_task,
  input  logic                  comp_collision_detected,
  output logic                  comp_status_ack,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic                  rf_wr,
  output logic                  rf_set,
  output logic                  rf_rd,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  output logic                  irq
);

  typedef enum logic [2:0] {
    IDLE, CPU_WR, CPU_RD, CPU_RDATA, CPU_DONE, COMP_SET, COMP_ACK
  } state_t;

  localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_q;
  logic [DATA_WIDTH-1:0] readdata_q;
  logic                  waitreq_q;
  logic                  ack_q;
  logic [ADDR_WIDTH-1:0] rf_addr_q;
  logic                  rf_wr_q;
  logic                  rf_set_q;
  logic                  rf_rd_q;
  logic [DATA_WIDTH-1:0] rf_wdata_q;
  logic                  irq_q;
  logic                  armed_q;

  logic cpu_req;
  logic comp_req;
  logic grant_cpu;
  logic grant_comp;

  assign cpu_req  = csr_read | csr_write;
  assign comp_req = comp_status_write & armed_q;

`ifdef CSR_ARB_ROUND_ROBIN_EN
  logic last_comp_q;  // 1 = comparator held the most recent grant
  assign grant_cpu  = cpu_req & (~comp_req | last_comp_q);
`else
  assign grant_cpu  = cpu_req & ~comp_req;
`endif
  assign grant_comp = comp_req & ~grant_cpu;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      readdata_q <= '0;
      waitreq_q  <= 1'b1;
      ack_q      <= 1'b0;
      rf_addr_q  <= '0;
      rf_wr_q    <= 1'b0;
      rf_set_q   <= 1'b0;
      rf_rd_q    <= 1'b0;
      rf_wdata_q <= '0;
      irq_q      <= 1'b0;
      armed_q    <= 1'b1;
`ifdef CSR_ARB_ROUND_ROBIN_EN
      last_comp_q <= 1'b1;
`endif
    end else begin
      // Strobes and the completion pulse default off so each lasts one cycle
      waitreq_q  <= 1'b1;
      ack_q      <= 1'b0;
      rf_wr_q    <= 1'b0;
      rf_set_q   <= 1'b0;
      rf_rd_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_wdata_q <= '0;
      if (!comp_status_write) armed_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (grant_cpu) begin
            rf_addr_q <= csr_address;
            if (csr_write) begin
              state_q    <= CPU_WR;
              rf_wr_q    <= 1'b1;
              rf_wdata_q <= csr_writedata;
              waitreq_q  <= 1'b0;
            end else begin
              state_q <= CPU_RD;
              rf_rd_q <= 1'b1;
            end
`ifdef CSR_ARB_ROUND_ROBIN_EN
            last_comp_q <= 1'b0;
`endif
          end else if (grant_comp) begin
            state_q    <= COMP_SET;
            rf_set_q   <= 1'b1;
            rf_addr_q  <= comp_collision_detected ? FAIL_ADDR : SUCCESS_ADDR;
            rf_wdata_q <= ONE << comp_current_task;
`ifdef CSR_ARB_ROUND_ROBIN_EN
            last_comp_q <= 1'b1;
`endif
          end
        end
        CPU_WR: begin
          if (rf_addr_q == EXC_ADDR) irq_q <= 1'b0;
          state_q <= IDLE;
        end
        CPU_RD: state_q <= CPU_RDATA;
        CPU_RDATA: begin
          readdata_q <= rf_rdata;
          waitreq_q  <= 1'b0;
          state_q    <= CPU_DONE;
        end
        CPU_DONE: state_q <= IDLE;
        COMP_SET: begin
          irq_q   <= 1'b1;
          ack_q   <= 1'b1;
          state_q <= COMP_ACK;
        end
        COMP_ACK: begin
          // Disarm so a request still held after its ack is not served twice
          if (comp_status_write) armed_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign csr_readdata    = readdata_q;
  assign csr_waitrequest = waitreq_q;
  assign comp_status_ack = ack_q;
  assign rf_addr         = rf_addr_q;
  assign rf_wr           = rf_wr_q;
  assign rf_set          = rf_set_q;
  assign rf_rd           = rf_rd_q;
  assign rf_wdata        = rf_wdata_q;
  assign irq             = irq_q;

endmodule

// File: tb/tb_csr_access_arbiter.sv
// Bench for csr_access_arbiter: directed vector table, multi-cycle corner sequences, and randomized traffic vs a register-level model.
module tb_csr_access_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam logic [AW-1:0] SUCC  = 10'h010;
  localparam logic [AW-1:0] F_ADR = 10'h011;
  localparam logic [AW-1:0] EXC   = 10'h012;

  logic          clk;
  logic          reset;
  logic [AW-1:0] csr_address;
  logic          csr_read;
  logic          csr_write;
  logic [DW-1:0] csr_writedata;
  logic [DW-1:0] csr_readdata;
  logic          csr_waitrequest;
  logic          comp_status_write;
  logic [KW-1:0] comp_current_task;
  logic          comp_collision_detected;
  logic          comp_status_ack;
  logic [AW-1:0] rf_addr;
  logic          rf_wr;
  logic          rf_set;
  logic          rf_rd;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] rf_rdata;
  logic          irq;

  csr_access_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .KEY_WIDTH(KW),
    .SUCCESS_ADDR(SUCC), .FAIL_ADDR(F_ADR), .EXC_ADDR(EXC)
  ) dut (
    .clk(clk), .reset(reset),
    .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write),
    .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
    .csr_waitrequest(csr_waitrequest),
    .comp_status_write(comp_status_write), .comp_current_task(comp_current_task),
    .comp_collision_detected(comp_collision_detected), .comp_status_ack(comp_status_ack),
    .rf_addr(rf_addr), .rf_wr(rf_wr), .rf_set(rf_set), .rf_rd(rf_rd),
    .rf_wdata(rf_wdata), .rf_rdata(rf_rdata), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file storage behind the arbiter
  logic          preload;
  logic [DW-1:0] mem [0:1023];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
      mem[10'h041] <= 32'hA5A5_0001;
    end else begin
      if (rf_wr)  mem[rf_addr] <= rf_wdata;
      if (rf_set) mem[rf_addr] <= mem[rf_addr] | rf_wdata;
      if (rf_rd)  rf_rdata     <= mem[rf_addr];
    end
  end

  int n_wr, n_rd, n_set;
  initial begin n_wr = 0; n_rd = 0; n_set = 0; end
  always @(negedge clk) begin
    if (rf_wr)  n_wr++;
    if (rf_rd)  n_rd++;
    if (rf_set) n_set++;
  end

  // Reference model: expected register contents and interrupt level
  logic [DW-1:0] exp_mem [0:1023];
  logic          exp_irq;
  int            exp_n_wr, exp_n_rd, exp_n_set;
  int            total, bad;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cpu_xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int lat, sc;
    logic [AW-1:0] sa;
    logic [DW-1:0] sd;
    lat = 0; sc = -1; sa = '0; sd = '0;
    csr_address = a; csr_writedata = d; csr_write = wr; csr_read = !wr;
    do begin
      tick();
      lat++;
      if ((wr && rf_wr) || (!wr && rf_rd)) begin sc = lat; sa = rf_addr; sd = rf_wdata; end
    end while (csr_waitrequest && lat < 20);
    chk(wr ? "wr_latency" : "rd_latency", 32'(lat), wr ? 32'd1 : 32'd3);
    chk(wr ? "rf_wr_cycle" : "rf_rd_cycle", 32'(sc), 32'd1);
    chk("rf_addr", 32'(sa), 32'(a));
    if (wr) begin
      chk("rf_wdata", sd, d);
      exp_mem[a] = d;
      if (a == EXC) exp_irq = 1'b0;
      exp_n_wr++;
    end else begin
      chk("csr_readdata", csr_readdata, exp_mem[a]);
      exp_n_rd++;
    end
    csr_write = 1'b0; csr_read = 1'b0;
    tick();
    chk("waitreq_high_after", 32'(csr_waitrequest), 32'd1);
    chk("irq_after_cpu", 32'(irq), 32'(exp_irq));
  endtask

  task automatic comp_xfer(input logic [KW-1:0] t, input logic coll, input int hold);
    int c, set_c, ack_c, extra_set, extra_ack;
    logic [AW-1:0] sa, ea;
    logic [DW-1:0] sd, one;
    logic irq_ack;
    c = 0; set_c = -1; ack_c = -1; extra_set = 0; extra_ack = 0;
    sa = '0; sd = '0; irq_ack = 1'b0; one = 1;
    comp_current_task = t; comp_collision_detected = coll; comp_status_write = 1'b1;
    do begin
      tick();
      c++;
      if (rf_set) begin set_c = c; sa = rf_addr; sd = rf_wdata; end
      if (comp_status_ack) begin ack_c = c; irq_ack = irq; end
    end while (!comp_status_ack && c < 20);
    ea = coll ? F_ADR : SUCC;
    chk("rf_set_cycle", 32'(set_c), 32'd1);
    chk("ack_cycle", 32'(ack_c), 32'd2);
    chk("set_addr", 32'(sa), 32'(ea));
    chk("set_wdata", sd, one << t);
    chk("irq_at_ack", 32'(irq_ack), 32'd1);
    exp_mem[ea] = exp_mem[ea] | (one << t);
    exp_irq = 1'b1;
    exp_n_set++;
    repeat (1 + hold) begin
      tick();
      if (rf_set) extra_set++;
      if (comp_status_ack) extra_ack++;
    end
    chk("no_second_set", 32'(extra_set), 32'd0);
    chk("ack_one_cycle", 32'(extra_ack), 32'd0);
    comp_status_write = 1'b0;
    tick();
  endtask

  typedef struct {
    int            op;   // 0 write, 1 read, 2 comparator
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [KW-1:0] t;
    logic          coll;
    int            hold;
    logic [DW-1:0] exp_rd;
    logic          exp_irq;
  } vec_t;

  vec_t vecs[14];
  logic [AW-1:0] addrs[7];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running want done");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_c, set_c;
    bit ack_seen;
    total = 0; bad = 0; exp_irq = 1'b0;
    exp_n_wr = 0; exp_n_rd = 0; exp_n_set = 0;
    for (int i = 0; i < 1024; i++) exp_mem[i] = '0;
    exp_mem[10'h041] = 32'hA5A5_0001;
    addrs = '{10'h040, 10'h041, 10'h042, 10'h043, SUCC, F_ADR, EXC};

    vecs[0]  = '{0, 10'h040, 32'h5, 4'd0,  1'b0, 0, 32'h0,         1'b0};
    vecs[1]  = '{1, 10'h040, 32'h0, 4'd0,  1'b0, 0, 32'h5,         1'b0};
    vecs[2]  = '{2, 10'h000, 32'h0, 4'd4,  1'b1, 3, 32'h0,         1'b1};
    vecs[3]  = '{1, F_ADR,   32'h0, 4'd0,  1'b0, 0, 32'h10,        1'b1};
    vecs[4]  = '{2, 10'h000, 32'h0, 4'd3,  1'b0, 0, 32'h0,         1'b1};
    vecs[5]  = '{1, SUCC,    32'h0, 4'd0,  1'b0, 0, 32'h8,         1'b1};
    vecs[6]  = '{0, SUCC,    32'h0, 4'd0,  1'b0, 0, 32'h0,         1'b1};
    vecs[7]  = '{1, SUCC,    32'h0, 4'd0,  1'b0, 0, 32'h0,         1'b1};
    vecs[8]  = '{2, 10'h000, 32'h0, 4'd0,  1'b1, 0, 32'h0,         1'b1};
    vecs[9]  = '{1, F_ADR,   32'h0, 4'd0,  1'b0, 0, 32'h11,        1'b1};
    vecs[10] = '{0, EXC,     32'h0, 4'd0,  1'b0, 0, 32'h0,         1'b0};
    vecs[11] = '{1, 10'h041, 32'h0, 4'd0,  1'b0, 0, 32'hA5A5_0001, 1'b0};
    vecs[12] = '{2, 10'h000, 32'h0, 4'd15, 1'b0, 0, 32'h0,         1'b1};
    vecs[13] = '{1, SUCC,    32'h0, 4'd0,  1'b0, 0, 32'h8000,      1'b1};

    reset = 1'b1; preload = 1'b1;
    csr_address = '0; csr_read = 1'b0; csr_write = 1'b0; csr_writedata = '0;
    comp_status_write = 1'b0; comp_current_task = '0; comp_collision_detected = 1'b0;
    repeat (3) tick();
    preload = 1'b0;
    chk("rst_waitreq", 32'(csr_waitrequest), 32'd1);
    chk("rst_readdata", csr_readdata, 32'd0);
    chk("rst_ack", 32'(comp_status_ack), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rf_strobes", {29'd0, rf_wr, rf_set, rf_rd}, 32'd0);
    chk("rst_rf_addr", 32'(rf_addr), 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    reset = 1'b0;
    tick();

    // Simultaneous CPU write and comparator request: first tie after reset
    csr_address = 10'h042; csr_writedata = 32'h7; csr_write = 1'b1;
    comp_current_task = 4'd3; comp_collision_detected = 1'b0; comp_status_write = 1'b1;
    wr_c = -1; set_c = -1; ack_seen = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (rf_wr && wr_c < 0) wr_c = c;
      if (rf_set && set_c < 0) begin set_c = c; chk("tie_set_wdata", rf_wdata, 32'h8); end
      if (csr_write && !csr_waitrequest) csr_write = 1'b0;
      if (comp_status_ack) ack_seen = 1'b1;
      else if (ack_seen) comp_status_write = 1'b0;
    end
`ifdef CSR_ARB_ROUND_ROBIN_EN
    chk("tie_wr_cycle", 32'(wr_c), 32'd1);
    chk("tie_set_cycle", 32'(set_c), 32'd3);
`else
    chk("tie_set_cycle", 32'(set_c), 32'd1);
    chk("tie_wr_cycle", 32'(wr_c), 32'd4);
`endif
    exp_mem[10'h042] = 32'h7; exp_mem[SUCC] = 32'h8; exp_irq = 1'b1;
    exp_n_wr++; exp_n_set++;
    chk("tie_irq", 32'(irq), 32'd1);
    tick();

    // Reset while the read sits in CPU_RDATA, then the master re-issues
    cpu_xfer(1'b0, 10'h041, '0);
    csr_address = 10'h042; csr_read = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_irq = 1'b0; exp_n_rd++;
    chk("midrd_waitreq", 32'(csr_waitrequest), 32'd1);
    chk("midrd_readdata", csr_readdata, 32'd0);
    chk("midrd_irq", 32'(irq), 32'd0);
    chk("midrd_rf_rd", 32'(rf_rd), 32'd0);
    cpu_xfer(1'b0, 10'h042, '0);

    for (int i = 0; i < 14; i++) begin
      case (vecs[i].op)
        0: cpu_xfer(1'b1, vecs[i].a, vecs[i].d);
        1: begin
          cpu_xfer(1'b0, vecs[i].a, '0);
          chk($sformatf("vec%0d_rd", i), csr_readdata, vecs[i].exp_rd);
        end
        default: comp_xfer(vecs[i].t, vecs[i].coll, vecs[i].hold);
      endcase
      chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
    end

    for (int i = 0; i < 150; i++) begin
      int op;
      op = int'($urandom_range(0, 2));
      if (op == 0)      cpu_xfer(1'b1, addrs[$urandom_range(0, 6)], $urandom);
      else if (op == 1) cpu_xfer(1'b0, addrs[$urandom_range(0, 6)], '0);
      else comp_xfer(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (2) tick();
    chk("count_rf_wr", 32'(n_wr), 32'(exp_n_wr));
    chk("count_rf_rd", 32'(n_rd), 32'(exp_n_rd));
    chk("count_rf_set", 32'(n_set), 32'(exp_n_set));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
